auth_seq_blk: RTL and testbench



---
 rtl/auth_seq_blk_if.sv | 18 +
 rtl/auth_seq_blk.sv | 198 +++++++++++++++++++
 tb/tb_auth_seq_blk.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/auth_seq_blk_if.sv
// UART receiver handshake bundle: byte, ready flag and the clear pulse back to the receiver.
interface auth_seq_blk_if;
    logic [7:0] rx_data;
    logic       rx_rdy;
    logic       clr_rx_rdy;

    modport master (
        output rx_data,
        output rx_rdy,
        input  clr_rx_rdy
    );

    modport slave (
        input  rx_data,
        input  rx_rdy,
        output clr_rx_rdy
    );
endinterface

// File: rtl/auth_seq_blk.sv
// Multi-byte key + GO power-up authenticator with rider_off hold, failure lockout and STOP disconnect.
// Optional build macro AUTH_TIMEOUT_EN adds an inter-byte timeout during key entry and ARMED.
module auth_seq_blk #(
    parameter int          KEY_LEN     = 4,
    parameter logic [63:0] KEY         = 64'h0000_0000_4B45_5931,
    parameter logic [7:0]  GO_CHAR     = 8'h47,
    parameter logic [7:0]  STOP_CHAR   = 8'h53,
    parameter logic [15:0] OFF_HOLD    = 16'd1000,
    parameter int          MAX_FAIL    = 3,
    parameter logic [23:0] LOCK_CYCLES = 24'd50000,
    parameter logic [23:0] TIMEOUT     = 24'd100000
) (
    input  logic                 clk,
    input  logic                 rst,
    auth_seq_blk_if.slave        rx,
    input  logic                 rider_off,
    output logic                 pwr_up,
    output logic                 locked,
    output logic [3:0]           fail_cnt,
    output logic [2:0]           state_o
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_KEY     = 3'd1,
        S_ARMED   = 3'd2,
        S_POWER   = 3'd3,
        S_DISC    = 3'd4,
        S_LOCKOUT = 3'd5
    } state_t;

    localparam logic [2:0]  IDX_LAST   = 3'(KEY_LEN - 1);
    localparam logic [3:0]  MAX_FAIL_V = 4'(MAX_FAIL);
    localparam logic [15:0] HOLD_LAST  = OFF_HOLD - 16'd1;
    localparam logic [23:0] LOCK_LAST  = LOCK_CYCLES - 24'd1;

    state_t      state, state_nxt;
    logic [2:0]  idx, idx_nxt;
    logic [3:0]  fail_nxt;
    logic [23:0] lock_cnt, lock_nxt;
    logic [15:0] hold_cnt, hold_nxt;
    logic        consume;
    logic        fail;
    logic        hold_expire;
    logic [3:0]  fail_inc;
    logic [7:0]  key_bytes [8];

    // Key is stored most-significant used byte first, so entry 0 is the first byte expected.
    for (genvar g = 0; g < 8; g++) begin : g_key
        if (g < KEY_LEN) begin : g_used
            assign key_bytes[g] = KEY[8*(KEY_LEN-1-g) +: 8];
        end else begin : g_unused
            assign key_bytes[g] = 8'h00;
        end
    end

    assign consume  = rx.rx_rdy && !rx.clr_rx_rdy;
    assign fail_inc = fail_cnt + 4'd1;
    assign state_o  = state;

`ifdef AUTH_TIMEOUT_EN
    localparam logic [23:0] TIMEOUT_LAST = TIMEOUT - 24'd1;
    logic [23:0] tmr, tmr_nxt;
`endif

    always_comb begin
        state_nxt   = state;
        idx_nxt     = idx;
        fail_nxt    = fail_cnt;
        lock_nxt    = lock_cnt;
        hold_nxt    = hold_cnt;
        fail        = 1'b0;
        hold_expire = 1'b0;
`ifdef AUTH_TIMEOUT_EN
        tmr_nxt     = tmr;
`endif

        case (state)
            S_IDLE, S_KEY: begin
                if (consume) begin
                    if (rx.rx_data == key_bytes[idx]) begin
                        if (idx == IDX_LAST) begin
                            state_nxt = S_ARMED;
                            idx_nxt   = 3'd0;
                        end else begin
                            state_nxt = S_KEY;
                            idx_nxt   = idx + 3'd1;
                        end
                    end else begin
                        fail = 1'b1;
                    end
                end
            end
            S_ARMED: begin
                if (consume) begin
                    if (rx.rx_data == GO_CHAR && !rider_off) begin
                        state_nxt = S_POWER;
                        fail_nxt  = 4'd0;
                        hold_nxt  = 16'd0;
                    end else begin
                        fail = 1'b1;
                    end
                end
            end
            S_POWER, S_DISC: begin
                if (rider_off) begin
                    if (hold_cnt == HOLD_LAST) begin
                        hold_expire = 1'b1;
                    end else begin
                        hold_nxt = hold_cnt + 16'd1;
                    end
                end else begin
                    hold_nxt = 16'd0;
                end
                // A hold expiry outranks a STOP arriving in the same cycle.
                if (hold_expire) begin
                    state_nxt = S_IDLE;
                    hold_nxt  = 16'd0;
                    idx_nxt   = 3'd0;
                end else if (state == S_POWER && consume && rx.rx_data == STOP_CHAR) begin
                    state_nxt = S_DISC;
                end
            end
            S_LOCKOUT: begin
                if (lock_cnt == 24'd0) begin
                    state_nxt = S_IDLE;
                end else begin
                    lock_nxt = lock_cnt - 24'd1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                idx_nxt   = 3'd0;
            end
        endcase

`ifdef AUTH_TIMEOUT_EN
        if (state == S_KEY || state == S_ARMED) begin
            if (consume) begin
                tmr_nxt = 24'd0;
            end else if (tmr == TIMEOUT_LAST) begin
                tmr_nxt = 24'd0;
                fail    = 1'b1;
            end else begin
                tmr_nxt = tmr + 24'd1;
            end
        end else begin
            tmr_nxt = 24'd0;
        end
`endif

        if (fail) begin
            idx_nxt = 3'd0;
            if (fail_inc == MAX_FAIL_V) begin
                state_nxt = S_LOCKOUT;
                fail_nxt  = 4'd0;
                lock_nxt  = LOCK_LAST;
            end else begin
                state_nxt = S_IDLE;
                fail_nxt  = fail_inc;
            end
        end
    end

    // Outputs are registered from the next state so they change on the same edge as the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            idx           <= 3'd0;
            fail_cnt      <= 4'd0;
            lock_cnt      <= 24'd0;
            hold_cnt      <= 16'd0;
            pwr_up        <= 1'b0;
            locked        <= 1'b0;
            rx.clr_rx_rdy <= 1'b0;
        end else begin
            state         <= state_nxt;
            idx           <= idx_nxt;
            fail_cnt      <= fail_nxt;
            lock_cnt      <= lock_nxt;
            hold_cnt      <= hold_nxt;
            pwr_up        <= (state_nxt == S_POWER) || (state_nxt == S_DISC);
            locked        <= (state_nxt == S_LOCKOUT);
            rx.clr_rx_rdy <= consume;
        end
    end

`ifdef AUTH_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            tmr <= 24'd0;
        end else begin
            tmr <= tmr_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_auth_seq_blk.sv
// Directed testbench for auth_seq_blk with shortened hold/lockout/timeout parameters.
module tb_auth_seq_blk;

    localparam logic [15:0] OFF_HOLD    = 16'd10;
    localparam logic [23:0] LOCK_CYCLES = 24'd20;
    localparam logic [23:0] TIMEOUT     = 24'd40;

    logic       clk = 1'b0;
    logic       rst;
    logic       rider_off;
    logic       pwr_up;
    logic       locked;
    logic [3:0] fail_cnt;
    logic [2:0] state_o;

    int errors = 0;
    int checks = 0;
    int bytes_sent = 0;
    int clr_seen = 0;

    auth_seq_blk_if bus();

    auth_seq_blk #(
        .KEY_LEN    (4),
        .KEY        (64'h0000_0000_4B45_5931),
        .GO_CHAR    (8'h47),
        .STOP_CHAR  (8'h53),
        .OFF_HOLD   (OFF_HOLD),
        .MAX_FAIL   (3),
        .LOCK_CYCLES(LOCK_CYCLES),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx       (bus),
        .rider_off(rider_off),
        .pwr_up   (pwr_up),
        .locked   (locked),
        .fail_cnt (fail_cnt),
        .state_o  (state_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.clr_rx_rdy) clr_seen++;
    end

    // Present one byte, let it be consumed at the next edge, then drop rx_rdy as the receiver would.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.rx_data = b;
        bus.rx_rdy  = 1'b1;
        bytes_sent++;
        @(posedge clk);
        #1;
        @(negedge clk);
        bus.rx_rdy = 1'b0;
    endtask

    task automatic send_key_go();
        send_byte(8'h4B);
        send_byte(8'h45);
        send_byte(8'h59);
        send_byte(8'h31);
        send_byte(8'h47);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (state_o !== 3'd0) begin errors++; $display("[TB] FAIL reset_state: got %0d expected 0", state_o); end
        checks++; if (pwr_up !== 1'b0) begin errors++; $display("[TB] FAIL reset_pwr: got %b expected 0", pwr_up); end
        checks++; if (locked !== 1'b0) begin errors++; $display("[TB] FAIL reset_locked: got %b expected 0", locked); end
        checks++; if (fail_cnt !== 4'd0) begin errors++; $display("[TB] FAIL reset_fail: got %0d expected 0", fail_cnt); end
        checks++; if (bus.clr_rx_rdy !== 1'b0) begin errors++; $display("[TB] FAIL reset_clr: got %b expected 0", bus.clr_rx_rdy); end
        rst = 1'b0;
    endtask

    task automatic test_key_power();
        send_byte(8'h4B);
        send_byte(8'h45);
        send_byte(8'h59);
        checks++; if (state_o !== 3'd1) begin errors++; $display("[TB] FAIL key_partial_state: got %0d expected 1", state_o); end
        send_byte(8'h31);
        checks++; if (state_o !== 3'd2) begin errors++; $display("[TB] FAIL key_armed_state: got %0d expected 2", state_o); end
        checks++; if (pwr_up !== 1'b0) begin errors++; $display("[TB] FAIL armed_pwr: got %b expected 0", pwr_up); end
        send_byte(8'h47);
        checks++; if (pwr_up !== 1'b1) begin errors++; $display("[TB] FAIL go_pwr: got %b expected 1", pwr_up); end
        checks++; if (state_o !== 3'd3) begin errors++; $display("[TB] FAIL go_state: got %0d expected 3", state_o); end
        checks++; if (fail_cnt !== 4'd0) begin errors++; $display("[TB] FAIL go_fail: got %0d expected 0", fail_cnt); end
        rider_off = 1'b1;
        repeat (9) @(posedge clk);
        #1;
        checks++; if (pwr_up !== 1'b1) begin errors++; $display("[TB] FAIL hold9_pwr: got %b expected 1", pwr_up); end
        @(posedge clk);
        #1;
        checks++; if (pwr_up !== 1'b0) begin errors++; $display("[TB] FAIL hold10_pwr: got %b expected 0", pwr_up); end
        checks++; if (state_o !== 3'd0) begin errors++; $display("[TB] FAIL hold10_state: got %0d expected 0", state_o); end
        @(negedge clk);
        rider_off = 1'b0;
    endtask

    task automatic test_bad_and_lockout();
        send_byte(8'h4B);
        send_byte(8'h58);
        checks++; if (state_o !== 3'd0) begin errors++; $display("[TB] FAIL bad1_state: got %0d expected 0", state_o); end
        checks++; if (fail_cnt !== 4'd1) begin errors++; $display("[TB] FAIL bad1_fail: got %0d expected 1", fail_cnt); end
        checks++; if (pwr_up !== 1'b0) begin errors++; $display("[TB] FAIL bad1_pwr: got %b expected 0", pwr_up); end
        // Second 'K' mismatches byte 1 and must not restart the key at byte 0.
        send_byte(8'h4B);
        send_byte(8'h4B);
        checks++; if (state_o !== 3'd0) begin errors++; $display("[TB] FAIL bad2_state: got %0d expected 0", state_o); end
        checks++; if (fail_cnt !== 4'd2) begin errors++; $display("[TB] FAIL bad2_fail: got %0d expected 2", fail_cnt); end
        send_byte(8'h5A);
        checks++; if (locked !== 1'b1) begin errors++; $display("[TB] FAIL lock_entry: got %b expected 1", locked); end
        checks++; if (state_o !== 3'd5) begin errors++; $display("[TB] FAIL lock_state: got %0d expected 5", state_o); end
        checks++; if (fail_cnt !== 4'd0) begin errors++; $display("[TB] FAIL lock_fail: got %0d expected 0", fail_cnt); end
        send_key_go();
        checks++; if (pwr_up !== 1'b0) begin errors++; $display("[TB] FAIL lock_key_pwr: got %b expected 0", pwr_up); end
        // Entry edge plus 10 cycles of bytes have elapsed; 9 more edges keep it locked, the 20th releases.
        repeat (9) @(posedge clk);
        #1;
        checks++; if (locked !== 1'b1) begin errors++; $display("[TB] FAIL lock_last_cycle: got %b expected 1", locked); end
        @(posedge clk);
        #1;
        checks++; if (locked !== 1'b0) begin errors++; $display("[TB] FAIL lock_release: got %b expected 0", locked); end
        checks++; if (state_o !== 3'd0) begin errors++; $display("[TB] FAIL lock_release_state: got %0d expected 0", state_o); end
        checks++; if (fail_cnt !== 4'd0) begin errors++; $display("[TB] FAIL lock_release_fail: got %0d expected 0", fail_cnt); end
    endtask

    task automatic test_stop_and_hold();
        send_key_go();
        send_byte(8'h53);
        checks++; if (state_o !== 3'd4) begin errors++; $display("[TB] FAIL stop_state: got %0d expected 4", state_o); end
        checks++; if (pwr_up !== 1'b1) begin errors++; $display("[TB] FAIL stop_pwr: got %b expected 1", pwr_up); end
        @(negedge clk);
        rider_off = 1'b1;
        repeat (9) @(negedge clk);
        rider_off = 1'b0;
        repeat (3) @(negedge clk);
        send_byte(8'h47);
        send_byte(8'h4B);
        checks++; if (pwr_up !== 1'b1) begin errors++; $display("[TB] FAIL short_hold_pwr: got %b expected 1", pwr_up); end
        checks++; if (state_o !== 3'd4) begin errors++; $display("[TB] FAIL short_hold_state: got %0d expected 4", state_o); end
        rider_off = 1'b1;
        repeat (9) @(negedge clk);
        checks++; if (pwr_up !== 1'b1) begin errors++; $display("[TB] FAIL disc_hold9_pwr: got %b expected 1", pwr_up); end
        @(negedge clk);
        checks++; if (pwr_up !== 1'b0) begin errors++; $display("[TB] FAIL disc_hold10_pwr: got %b expected 0", pwr_up); end
        checks++; if (state_o !== 3'd0) begin errors++; $display("[TB] FAIL disc_hold10_state: got %0d expected 0", state_o); end
        rider_off = 1'b0;
    endtask

    task automatic test_go_rider_off();
        send_byte(8'h4B);
        send_byte(8'h45);
        send_byte(8'h59);
        send_byte(8'h31);
        rider_off = 1'b1;
        send_byte(8'h47);
        checks++; if (pwr_up !== 1'b0) begin errors++; $display("[TB] FAIL go_off_pwr: got %b expected 0", pwr_up); end
        checks++; if (fail_cnt !== 4'd1) begin errors++; $display("[TB] FAIL go_off_fail: got %0d expected 1", fail_cnt); end
        checks++; if (state_o !== 3'd0) begin errors++; $display("[TB] FAIL go_off_state: got %0d expected 0", state_o); end
        rider_off = 1'b0;
    endtask

    task automatic test_back_to_back();
        send_key_go();
        checks++; if (fail_cnt !== 4'd0) begin errors++; $display("[TB] FAIL b2b_fail: got %0d expected 0", fail_cnt); end
        checks++; if (state_o !== 3'd3) begin errors++; $display("[TB] FAIL b2b_state: got %0d expected 3", state_o); end
        // STOP lands on the same edge as hold expiry; expiry must win.
        @(negedge clk);
        rider_off = 1'b1;
        repeat (8) @(negedge clk);
        send_byte(8'h53);
        checks++; if (state_o !== 3'd0) begin errors++; $display("[TB] FAIL stop_vs_hold_state: got %0d expected 0", state_o); end
        checks++; if (pwr_up !== 1'b0) begin errors++; $display("[TB] FAIL stop_vs_hold_pwr: got %b expected 0", pwr_up); end
        rider_off = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (clr_seen !== bytes_sent) begin errors++; $display("[TB] FAIL clr_pulses: got %0d expected %0d", clr_seen, bytes_sent); end
    endtask

    task automatic test_reset_mid();
        send_key_go();
        checks++; if (pwr_up !== 1'b1) begin errors++; $display("[TB] FAIL mid_pre_pwr: got %b expected 1", pwr_up); end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (pwr_up !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_pwr: got %b expected 0", pwr_up); end
        checks++; if (state_o !== 3'd0) begin errors++; $display("[TB] FAIL mid_rst_state: got %0d expected 0", state_o); end
        checks++; if (fail_cnt !== 4'd0) begin errors++; $display("[TB] FAIL mid_rst_fail: got %0d expected 0", fail_cnt); end
        checks++; if (bus.clr_rx_rdy !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_clr: got %b expected 0", bus.clr_rx_rdy); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_timeout();
        send_byte(8'h4B);
        send_byte(8'h45);
        repeat (60) @(negedge clk);
`ifdef AUTH_TIMEOUT_EN
        checks++; if (state_o !== 3'd0) begin errors++; $display("[TB] FAIL timeout_state: got %0d expected 0", state_o); end
        checks++; if (fail_cnt !== 4'd1) begin errors++; $display("[TB] FAIL timeout_fail: got %0d expected 1", fail_cnt); end
`else
        checks++; if (state_o !== 3'd1) begin errors++; $display("[TB] FAIL no_timeout_state: got %0d expected 1", state_o); end
        checks++; if (fail_cnt !== 4'd0) begin errors++; $display("[TB] FAIL no_timeout_fail: got %0d expected 0", fail_cnt); end
`endif
    endtask

    initial begin
        rst         = 1'b1;
        rider_off   = 1'b0;
        bus.rx_data = 8'h00;
        bus.rx_rdy  = 1'b0;
        test_reset();
        test_key_power();
        test_bad_and_lockout();
        test_stop_and_hold();
        test_go_rider_off();
        test_back_to_back();
        test_reset_mid();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
